// File: rtl/key_cmd_pkg.sv
// Shared command encoding, key bit positions and repeat FSM states for key_command_decoder.
package key_cmd_pkg;

    localparam int unsigned CMD_W = 3;

    typedef enum logic [CMD_W-1:0] {
        CMD_UP      = 3'd0,
        CMD_DOWN    = 3'd1,
        CMD_LEFT    = 3'd2,
        CMD_RIGHT   = 3'd3,
        CMD_RESTART = 3'd4
    } cmd_e;

    localparam int unsigned KEY_UP      = 0;
    localparam int unsigned KEY_DOWN    = 1;
    localparam int unsigned KEY_LEFT    = 2;
    localparam int unsigned KEY_RIGHT   = 3;
    localparam int unsigned KEY_RESTART = 4;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_e;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with flush; a flush with a coincident push leaves that push as the sole entry.
module cmd_fifo
    import key_cmd_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = CMD_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   cnt;
    logic          pop_eff;
    logic          push_eff;

    assign empty    = (cnt == '0);
    assign full     = (cnt == (AW+1)'(DEPTH));
    assign pop_eff  = pop & ~empty;
    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign push_eff = push & (~full | pop_eff);
    assign count    = cnt;
    assign dout     = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            if (push) begin
                mem[0] <= din;
                wr_ptr <= AW'(1);
                cnt    <= (AW+1)'(1);
            end else begin
                wr_ptr <= '0;
                cnt    <= '0;
            end
        end else begin
            if (push_eff) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt <= cnt + (AW+1)'(push_eff) - (AW+1)'(pop_eff);
        end
    end

endmodule

// File: rtl/key_command_decoder.sv
// Debounced key levels -> prioritised, queued game commands behind a valid/ready handshake.
// Optional auto-repeat of held direction keys is enabled by defining KEY_AUTOREPEAT_EN.
module key_command_decoder
    import key_cmd_pkg::*;
#(
    parameter int unsigned NKEYS         = 18,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter logic [23:0] REPEAT_DELAY  = 24'd12_500_000,
    parameter logic [23:0] REPEAT_PERIOD = 24'd5_000_000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NKEYS-1:0]              key_in,
    input  logic                          cmd_ready,
    output logic                          cmd_valid,
    output logic [CMD_W-1:0]              cmd,
    output logic [$clog2(FIFO_DEPTH):0]   cmd_count,
    output logic                          overflow
);

    logic [NKEYS-1:0] s1;
    logic [NKEYS-1:0] s2;
    logic [NKEYS-1:0] s3;
    logic [4:0]       press;
    logic             edge_push;
    logic             restart;
    cmd_e             edge_cmd;
    logic             push;
    cmd_e             push_cmd;
    logic             pop;
    logic             full;
    logic             empty;
    logic             unused_bits;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '1;
            s2 <= '1;
            s3 <= '1;
        end else begin
            s1 <= key_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Keys are active-low: a press is a released->pressed step between history and current.
    assign press       = s3[4:0] & ~s2[4:0];
    assign unused_bits = ^s3;

    always_comb begin
        edge_push = 1'b0;
        restart   = 1'b0;
        edge_cmd  = CMD_UP;
        if (press[KEY_RESTART]) begin
            edge_push = 1'b1;
            restart   = 1'b1;
            edge_cmd  = CMD_RESTART;
        end else if (press[KEY_UP]) begin
            edge_push = 1'b1;
            edge_cmd  = CMD_UP;
        end else if (press[KEY_DOWN]) begin
            edge_push = 1'b1;
            edge_cmd  = CMD_DOWN;
        end else if (press[KEY_LEFT]) begin
            edge_push = 1'b1;
            edge_cmd  = CMD_LEFT;
        end else if (press[KEY_RIGHT]) begin
            edge_push = 1'b1;
            edge_cmd  = CMD_RIGHT;
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    rpt_state_e  rpt_state;
    cmd_e        rpt_cmd;
    logic [23:0] rpt_cnt;
    logic [3:0]  dir_held;
    logic        rpt_held;
    logic        rpt_push;

    assign dir_held = ~s2[3:0];
    assign rpt_held = dir_held[rpt_cmd[1:0]];
    // Fires on the edge where the count reaches zero; any press edge this cycle wins instead.
    assign rpt_push = (rpt_state != RPT_IDLE) && rpt_held && (rpt_cnt <= 24'd1) && !edge_push;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt_state <= RPT_IDLE;
            rpt_cmd   <= CMD_UP;
            rpt_cnt   <= '0;
        end else if (edge_push) begin
            if (restart) begin
                rpt_state <= RPT_IDLE;
                rpt_cnt   <= '0;
            end else begin
                rpt_state <= RPT_DELAY;
                rpt_cmd   <= edge_cmd;
                rpt_cnt   <= REPEAT_DELAY;
            end
        end else if (rpt_state != RPT_IDLE) begin
            if (!rpt_held) begin
                rpt_state <= RPT_IDLE;
                rpt_cnt   <= '0;
            end else if (rpt_cnt <= 24'd1) begin
                rpt_state <= RPT_REPEAT;
                rpt_cnt   <= REPEAT_PERIOD;
            end else begin
                rpt_cnt <= rpt_cnt - 24'd1;
            end
        end
    end

    assign push     = edge_push | rpt_push;
    assign push_cmd = edge_push ? edge_cmd : rpt_cmd;
`else
    localparam logic [47:0] unused_rpt = {REPEAT_DELAY, REPEAT_PERIOD};

    assign push     = edge_push;
    assign push_cmd = edge_cmd;
`endif

    assign cmd_valid = ~empty;
    assign pop       = cmd_valid & cmd_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (restart) begin
            overflow <= 1'b0;
        end else if (push && full && !pop) begin
            overflow <= 1'b1;
        end
    end

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (restart),
        .din   (push_cmd),
        .dout  (cmd),
        .full  (full),
        .empty (empty),
        .count (cmd_count)
    );

endmodule

// File: tb/tb_key_command_decoder.sv
// Scoreboard bench for key_command_decoder; repeat timing is checked when KEY_AUTOREPEAT_EN is defined.
module tb_key_command_decoder;

    localparam int unsigned NKEYS = 18;
    localparam int unsigned DEPTH = 4;
`ifdef KEY_AUTOREPEAT_EN
    localparam logic [23:0] RD = 24'd10;
    localparam logic [23:0] RP = 24'd4;
`else
    localparam logic [23:0] RD = 24'd12_500_000;
    localparam logic [23:0] RP = 24'd5_000_000;
`endif

    logic                     clk;
    logic                     rst;
    logic [NKEYS-1:0]         key_in;
    logic                     cmd_ready;
    logic                     cmd_valid;
    logic [2:0]               cmd;
    logic [$clog2(DEPTH):0]   cmd_count;
    logic                     overflow;

    int         checks = 0;
    int         errors = 0;
    int         pops   = 0;
    int         cyc    = 0;
    logic [2:0] sb[$];
    int         pop_cyc[$];

    key_command_decoder #(
        .NKEYS         (NKEYS),
        .FIFO_DEPTH    (DEPTH),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .cmd_ready (cmd_ready),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_count (cmd_count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: every accepted command is compared with the oldest expected entry.
    always @(negedge clk) begin
        if (rst && cmd_valid && cmd_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got cmd %0d expected no command", cmd);
            end else begin
                check("pop_cmd", int'(cmd), int'(sb.pop_front()));
            end
            pops++;
            pop_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drain();
        cmd_ready = 1'b1;
        for (int i = 0; i < 40 && cmd_count != 0; i++) step(1);
        cmd_ready = 1'b0;
        check("drain_count", int'(cmd_count), 0);
    endtask

    task automatic fill4();
        for (int b = 0; b < 4; b++) begin
            key_in[b] = 1'b0;
            sb.push_back(3'(b));
            step(1);
        end
        step(3);
        key_in = '1;
        step(3);
    endtask

    initial begin
        int base;
        rst       = 1'b0;
        key_in    = '1;
        cmd_ready = 1'b0;
        #1;
        check("rst_valid", int'(cmd_valid), 0);
        check("rst_cmd", int'(cmd), 0);
        check("rst_count", int'(cmd_count), 0);
        check("rst_overflow", int'(overflow), 0);
        step(2);
        rst = 1'b1;
        step(3);
        check("idle_valid", int'(cmd_valid), 0);

        // Single LEFT press: three-edge latency, release adds nothing.
        key_in[2] = 1'b0;
        sb.push_back(3'd2);
        step(1);
        check("left_e0_valid", int'(cmd_valid), 0);
        step(1);
        check("left_e1_valid", int'(cmd_valid), 0);
        step(1);
        check("left_e2_valid", int'(cmd_valid), 1);
        check("left_cmd", int'(cmd), 2);
        check("left_count", int'(cmd_count), 1);
        step(7);
        key_in[2] = 1'b1;
        step(5);
        check("left_release_count", int'(cmd_count), 1);
        drain();

        // UP and RIGHT together: UP wins, RIGHT discarded.
        key_in[0] = 1'b0;
        key_in[3] = 1'b0;
        sb.push_back(3'd0);
        step(3);
        check("prio_count", int'(cmd_count), 1);
        check("prio_cmd", int'(cmd), 0);
        step(2);
        key_in = '1;
        step(3);
        check("prio_count_after", int'(cmd_count), 1);
        drain();

        // Overflow on fifth press, then RESTART flushes and clears it.
        fill4();
        check("full_count", int'(cmd_count), 4);
        check("full_overflow", int'(overflow), 0);
        key_in[0] = 1'b0;
        step(4);
        check("ovf_count", int'(cmd_count), 4);
        check("ovf_flag", int'(overflow), 1);
        check("ovf_head", int'(cmd), 0);
        key_in = '1;
        step(3);
        key_in[4] = 1'b0;
        sb.delete();
        sb.push_back(3'd4);
        step(3);
        check("restart_count", int'(cmd_count), 1);
        check("restart_cmd", int'(cmd), 4);
        check("restart_overflow", int'(overflow), 0);
        key_in = '1;
        step(3);
        drain();

        // Full FIFO with push and pop on the same edge.
        fill4();
        check("full2_count", int'(cmd_count), 4);
        key_in[2] = 1'b0;
        sb.push_back(3'd2);
        step(2);
        cmd_ready = 1'b1;
        step(1);
        cmd_ready = 1'b0;
        check("pushpop_count", int'(cmd_count), 4);
        check("pushpop_overflow", int'(overflow), 0);
        check("pushpop_head", int'(cmd), 1);
        key_in = '1;
        step(3);
        drain();

        // Asynchronous reset with entries queued; DOWN held through reset release.
        for (int b = 0; b < 3; b++) begin
            key_in[b] = 1'b0;
            sb.push_back(3'(b));
            step(1);
        end
        step(3);
        key_in = '1;
        step(3);
        check("preq_count", int'(cmd_count), 3);
        #1;
        rst       = 1'b0;
        key_in[1] = 1'b0;
        #1;
        check("async_valid", int'(cmd_valid), 0);
        check("async_count", int'(cmd_count), 0);
        sb.delete();
        step(2);
        rst = 1'b1;
        sb.push_back(3'd1);
        step(3);
        check("held_count", int'(cmd_count), 1);
        check("held_cmd", int'(cmd), 1);
        step(5);
        check("held_once", int'(cmd_count), 1);
        key_in = '1;
        step(3);
        drain();

        // DOWN held for 30 cycles with the consumer always ready.
        base = pops;
        pop_cyc.delete();
        cmd_ready = 1'b1;
        key_in[1] = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        repeat (6) sb.push_back(3'd1);
`else
        sb.push_back(3'd1);
`endif
        step(30);
        key_in[1] = 1'b1;
        step(10);
        cmd_ready = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        check("hold_pops", pops - base, 6);
        if (pop_cyc.size() == 6) begin
            check("rpt_first_gap", pop_cyc[1] - pop_cyc[0], 10);
            for (int i = 2; i < 6; i++) check("rpt_gap", pop_cyc[i] - pop_cyc[i-1], 4);
        end
`else
        check("hold_pops", pops - base, 1);
`endif
        check("hold_count", int'(cmd_count), 0);

        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
